// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad matrix scanner: column strobing, per-scan snapshot,
// single-key detection and press/release debounce.
//
// state      | meaning
// IDLE       | no key accepted, waiting for a single-key scan
// PRESS_DB   | counting consecutive scans of the same candidate key
// HELD       | key accepted and reported down
// RELEASE_DB | counting consecutive empty scans before reporting release
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] iRow,
  output logic [3:0] oCol,
  output logic [3:0] oKeyCode,
  output logic       oKeyValid,
  output logic       oKeyDown
);

  localparam int             DW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]     DB_TARGET  = 4'(DEBOUNCE_SCANS);
  localparam bit             DB_ONE     = (DEBOUNCE_SCANS <= 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } state_t;

  logic [3:0]    row_meta_q, row_sync_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    col_n_q, col_n_d;
  logic [15:0]   snap_q, snap_d, snap_cur;
  state_t        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    match_q, match_d;
  logic [3:0]    rel_q, rel_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          down_q, down_d;

  logic          sample_en, scan_done, single;
  logic [4:0]    hit_cnt;
  logic [3:0]    hit_idx;
  logic [3:0]    bit_idx;
  logic [3:0]    match_inc, rel_inc;

  function automatic logic [3:0] sat_inc(input logic [3:0] x);
    return (x == 4'hF) ? x : x + 4'd1;
  endfunction

  assign sample_en = (dwell_q == DWELL_LAST);
  assign scan_done = sample_en && (col_q == 2'd3);
  assign match_inc = sat_inc(match_q);
  assign rel_inc   = sat_inc(rel_q);

  always_comb begin
    dwell_d = sample_en ? '0 : dwell_q + DW'(1);
    col_d   = sample_en ? col_q + 2'd1 : col_q;
    col_n_d = ~(4'b0001 << col_d);
  end

  // Snapshot including the sample taken this cycle, so the column-3 bits are
  // visible to the scan-result decode on the same edge.
  always_comb begin
    snap_cur = snap_q;
    bit_idx  = '0;
    if (sample_en) begin
      for (int r = 0; r < 4; r++) begin
        bit_idx           = {2'(r), col_q};
        snap_cur[bit_idx] = ~row_sync_q[r];
      end
    end
    snap_d = scan_done ? '0 : snap_cur;
  end

  always_comb begin
    hit_cnt = '0;
    hit_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap_cur[i]) begin
        hit_cnt = hit_cnt + 5'd1;
        hit_idx = 4'(i);
      end
    end
    single = (hit_cnt == 5'd1);
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    match_d = match_q;
    rel_d   = rel_q;
    code_d  = code_q;
    valid_d = 1'b0;
    down_d  = down_q;
    if (scan_done) begin
      unique case (state_q)
        ST_IDLE: begin
          if (single) begin
            cand_d  = hit_idx;
            match_d = 4'd1;
            if (DB_ONE) begin
              state_d = ST_HELD;
              code_d  = hit_idx;
              valid_d = 1'b1;
              down_d  = 1'b1;
            end else begin
              state_d = ST_PRESS_DB;
            end
          end
        end
        ST_PRESS_DB: begin
          if (!single) begin
            state_d = ST_IDLE;
          end else if (hit_idx == cand_q) begin
            match_d = match_inc;
            if (match_inc >= DB_TARGET) begin
              state_d = ST_HELD;
              code_d  = cand_q;
              valid_d = 1'b1;
              down_d  = 1'b1;
            end
          end else begin
            cand_d  = hit_idx;
            match_d = 4'd1;
          end
        end
        ST_HELD: begin
          // A different single key while held is deliberately ignored.
          if (!single) begin
            rel_d = 4'd1;
            if (DB_ONE) begin
              state_d = ST_IDLE;
              down_d  = 1'b0;
            end else begin
              state_d = ST_RELEASE_DB;
            end
          end
        end
        ST_RELEASE_DB: begin
          if (single) begin
            state_d = ST_HELD;
          end else begin
            rel_d = rel_inc;
            if (rel_inc >= DB_TARGET) begin
              state_d = ST_IDLE;
              down_d  = 1'b0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      dwell_q    <= '0;
      col_q      <= 2'd0;
      col_n_q    <= 4'b1110;
      snap_q     <= '0;
      state_q    <= ST_IDLE;
      cand_q     <= 4'h0;
      match_q    <= 4'h0;
      rel_q      <= 4'h0;
      code_q     <= 4'h0;
      valid_q    <= 1'b0;
      down_q     <= 1'b0;
    end else begin
      row_meta_q <= iRow;
      row_sync_q <= row_meta_q;
      dwell_q    <= dwell_d;
      col_q      <= col_d;
      col_n_q    <= col_n_d;
      snap_q     <= snap_d;
      state_q    <= state_d;
      cand_q     <= cand_d;
      match_q    <= match_d;
      rel_q      <= rel_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      down_q     <= down_d;
    end
  end

  assign oCol      = col_n_q;
  assign oKeyCode  = code_q;
  assign oKeyValid = valid_q;
  assign oKeyDown  = down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a simulated key matrix, a scan-level debounce
// model checked every cycle, directed segments and random key sequences.
module tb_keypad_scanner;
  localparam int SD   = 4;
  localparam int DB   = 2;
  localparam int SCAN = 4 * SD;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] iRow, oCol, oKeyCode;
  logic       oKeyValid, oKeyDown;
  logic [15:0] pressed = 16'h0000;

  int tests = 0;
  int fails = 0;

  int         cyc;
  bit         held;
  int         run_key, run_len;
  logic       e_valid, e_down;
  logic [3:0] e_code;
  int         pulses;

  typedef struct {
    logic [15:0] keys;
    int          scans;
    int          exp_pulses;
    logic [3:0]  exp_code;
    logic        exp_down;
  } seg_t;
  seg_t tbl [13];

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .rst(rst), .iRow(iRow), .oCol(oCol),
    .oKeyCode(oKeyCode), .oKeyValid(oKeyValid), .oKeyDown(oKeyDown)
  );

  // Passive matrix: a closed key pulls its row low while its column is driven.
  always_comb begin
    iRow = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && oCol[c] == 1'b0) iRow[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // Scan-level reference: outputs follow runs of identical scan results.
  task automatic model_edge();
    int res;
    if (rst) begin
      cyc = 0; held = 0; run_key = -2; run_len = 0;
      e_valid = 0; e_down = 0; e_code = 4'h0;
    end else begin
      cyc++;
      e_valid = 0;
      if (cyc % SCAN == 0) begin
        res = -1;
        if ($countones(pressed) == 1)
          for (int i = 0; i < 16; i++) if (pressed[i]) res = i;
        if (res == run_key) run_len++;
        else begin run_key = res; run_len = 1; end
        if (!held && res >= 0 && run_len == DB) begin
          held = 1; e_valid = 1; e_down = 1; e_code = 4'(res);
        end else if (held && res < 0 && run_len == DB) begin
          held = 0; e_down = 0;
        end
      end
    end
  endtask

  task automatic step();
    logic [3:0] e_col;
    @(posedge clk);
    model_edge();
    #1;
    e_col = ~(4'b0001 << ((cyc / SD) % 4));
    chk("oCol", {12'h0, oCol}, {12'h0, e_col});
    chk("oKeyValid", {15'h0, oKeyValid}, {15'h0, e_valid});
    chk("oKeyDown", {15'h0, oKeyDown}, {15'h0, e_down});
    chk("oKeyCode", {12'h0, oKeyCode}, {12'h0, e_code});
    if (oKeyValid === 1'b1) pulses++;
  endtask

  task automatic run_scans(input logic [15:0] keys, input int n);
    pressed = keys;
    pulses  = 0;
    for (int i = 0; i < n * SCAN; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] keys, last_single;
    int k, a, b;
    rst = 1'b1;
    tbl[0]  = '{16'h0000, 12, 0, 4'h0, 1'b0};
    tbl[1]  = '{16'h0200,  4, 1, 4'h9, 1'b1};
    tbl[2]  = '{16'h0000,  1, 0, 4'h9, 1'b1};
    tbl[3]  = '{16'h0000,  1, 0, 4'h9, 1'b0};
    tbl[4]  = '{16'h0008,  1, 0, 4'h9, 1'b0};
    tbl[5]  = '{16'h0020,  3, 1, 4'h5, 1'b1};
    tbl[6]  = '{16'h0000,  2, 0, 4'h5, 1'b0};
    tbl[7]  = '{16'h0401,  3, 0, 4'h5, 1'b0};
    tbl[8]  = '{16'h0001,  2, 1, 4'h0, 1'b1};
    tbl[9]  = '{16'h0400,  3, 0, 4'h0, 1'b1};
    tbl[10] = '{16'h0000,  1, 0, 4'h0, 1'b1};
    tbl[11] = '{16'h0040,  1, 0, 4'h0, 1'b1};
    tbl[12] = '{16'h0000,  2, 0, 4'h0, 1'b0};

    step(); step();
    do_reset();
    chk("reset_oCol", {12'h0, oCol}, 16'h000E);
    chk("reset_oKeyDown", {15'h0, oKeyDown}, 16'h0000);

    for (int s = 0; s < 13; s++) begin
      run_scans(tbl[s].keys, tbl[s].scans);
      chk($sformatf("seg%0d_pulses", s), 16'(pulses), 16'(tbl[s].exp_pulses));
      chk($sformatf("seg%0d_code", s), {12'h0, oKeyCode}, {12'h0, tbl[s].exp_code});
      chk($sformatf("seg%0d_down", s), {15'h0, oKeyDown}, {15'h0, tbl[s].exp_down});
    end

    // Key held through a mid-scan reset must be re-debounced and re-reported.
    run_scans(16'h0200, 3);
    chk("pre_reset_pulses", 16'(pulses), 16'd1);
    for (int i = 0; i < 7; i++) step();
    do_reset();
    chk("midreset_oKeyDown", {15'h0, oKeyDown}, 16'h0000);
    chk("midreset_oKeyValid", {15'h0, oKeyValid}, 16'h0000);
    chk("midreset_oKeyCode", {12'h0, oKeyCode}, 16'h0000);
    chk("midreset_oCol", {12'h0, oCol}, 16'h000E);
    run_scans(16'h0200, 1);
    chk("post_reset_scan1_pulses", 16'(pulses), 16'd0);
    run_scans(16'h0200, 1);
    chk("post_reset_scan2_pulses", 16'(pulses), 16'd1);
    chk("post_reset_code", {12'h0, oKeyCode}, 16'h0009);
    run_scans(16'h0000, 2);
    chk("post_reset_release", {15'h0, oKeyDown}, 16'h0000);

    last_single = 16'h0001;
    for (int s = 0; s < 80; s++) begin
      k = $urandom_range(0, 9);
      if (k < 4) keys = 16'h0000;
      else if (k < 8) begin
        if ($urandom_range(0, 1) == 1) keys = last_single;
        else keys = 16'h0001 << $urandom_range(0, 15);
        last_single = keys;
      end else begin
        a = $urandom_range(0, 15);
        b = (a + 1 + $urandom_range(0, 14)) % 16;
        keys = (16'h0001 << a) | (16'h0001 << b);
      end
      run_scans(keys, $urandom_range(1, 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
